// File: rtl/cgra_stream_pkg.sv
// Shared types and helpers for the CGRA egress stream arbiter.
package cgra_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  localparam logic MODE_ORDERED = 1'b0;
  localparam logic MODE_RR      = 1'b1;

  // Widest one-hot vector onehot_to_idx accepts; callers zero-extend.
  localparam int MAX_COL = 32;

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic int onehot_to_idx(input logic [MAX_COL-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_COL; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/cgra_stream_arbiter_if.sv
// Bundle of the arbiter's control, per-column ingress and egress stream signals.
interface cgra_stream_arbiter_if #(
  parameter int NUM_COL = 4,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16
);
  logic                      start;
  logic                      mode;
  logic [CNT_W-1:0]          pkt_limit;
  logic [NUM_COL-1:0]        col_tvalid;
  logic [NUM_COL*DATA_W-1:0] col_tdata;
  logic [NUM_COL-1:0]        col_tlast;
  logic [NUM_COL-1:0]        col_tready;
  logic                      m_tvalid;
  logic [DATA_W-1:0]         m_tdata;
  logic                      m_tlast;
  logic                      m_tready;
  logic [NUM_COL-1:0]        grant;
  logic                      busy;
  logic                      done;
  logic [CNT_W-1:0]          pkt_count;

  // Arbiter side: drives the egress stream and status.
  modport master (
    input  start, mode, pkt_limit, col_tvalid, col_tdata, col_tlast, m_tready,
    output col_tready, m_tvalid, m_tdata, m_tlast, grant, busy, done, pkt_count
  );

  // Environment side: column sources, egress sink and session control.
  modport slave (
    output start, mode, pkt_limit, col_tvalid, col_tdata, col_tlast, m_tready,
    input  col_tready, m_tvalid, m_tdata, m_tlast, grant, busy, done, pkt_count
  );
endinterface

// File: rtl/cgra_rr_pick.sv
// Wrap-around priority search: first requesting column at or after ptr.
module cgra_rr_pick #(
  parameter int NUM_COL = 4,
  parameter int PTR_W   = $clog2(NUM_COL)
) (
  input  logic [NUM_COL-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   idx,
  output logic               found
);

  // ptr + k wrapped at NUM_COL, which need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_COL) s = s - NUM_COL;
    return PTR_W'(s);
  endfunction

  // Scan NUM_COL candidates starting at ptr; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_COL; i++) begin
      if (!found && req[wrap_add(ptr, i)]) begin
        found = 1'b1;
        idx   = wrap_add(ptr, i);
      end
    end
  end

endmodule

// File: rtl/cgra_stream_arbiter.sv
// Packet-level arbiter sharing the CGRA egress stream between column streams.
import cgra_stream_pkg::*;

module cgra_stream_arbiter #(
  parameter int NUM_COL = 4,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16
) (
  input logic                   clk,
  input logic                   rst,
  cgra_stream_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(NUM_COL);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_COL - 1);

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic               r_mode;
  logic [CNT_W-1:0]   r_limit;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_COL-1:0] r_grant;
  logic               r_done;

  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic [PTR_W-1:0]   w_cand_idx;
  logic               w_cand_found;
  logic [PTR_W-1:0]   w_gidx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [CNT_W-1:0]   w_count_inc;
  logic               w_last_beat;
  logic               w_session_end;
  logic               w_tvalid;
  logic               w_tlast;
  logic [DATA_W-1:0]  w_tdata;
  logic [NUM_COL-1:0] w_col_tready;

  cgra_rr_pick #(.NUM_COL(NUM_COL), .PTR_W(PTR_W)) u_pick (
    .req   (bus.col_tvalid),
    .ptr   (r_ptr),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  assign w_gidx      = PTR_W'(onehot_to_idx(MAX_COL'(r_grant)));
  assign w_next_ptr  = (w_gidx == LAST_IDX) ? '0 : w_gidx + 1'b1;
  assign w_count_inc = r_count + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state, candidate selection and the egress mux of the granted column.
  always_comb begin
    w_next        = r_state;
    w_cand_found  = 1'b0;
    w_cand_idx    = r_ptr;
    w_last_beat   = 1'b0;
    w_session_end = 1'b0;
    w_tvalid      = 1'b0;
    w_tlast       = 1'b0;
    w_tdata       = '0;
    w_col_tready  = '0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) w_next = ARB;
      end
      ARB: begin
        if (r_mode == MODE_RR) begin
          w_cand_found = w_pick_found;
          w_cand_idx   = w_pick_idx;
        end else begin
          w_cand_found = bus.col_tvalid[r_ptr];
        end
        if (w_cand_found) w_next = XFER;
      end
      XFER: begin
        w_tvalid             = bus.col_tvalid[w_gidx];
        w_tlast              = bus.col_tlast[w_gidx];
        w_tdata              = bus.col_tdata[int'(w_gidx)*DATA_W +: DATA_W];
        w_col_tready[w_gidx] = bus.m_tready;
        w_last_beat          = w_tvalid && bus.m_tready && w_tlast;
        if (w_last_beat) begin
          if (r_mode == MODE_ORDERED) w_session_end = (w_gidx == LAST_IDX);
          else w_session_end = (r_limit != '0) && (w_count_inc == r_limit);
          w_next = w_session_end ? IDLE : ARB;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Session registers: latched config, pointer, grant, packet count, done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_mode  <= MODE_ORDERED;
      r_limit <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mode  <= bus.mode;
            r_limit <= bus.pkt_limit;
            r_ptr   <= '0;
            r_count <= '0;
          end
        end
        ARB: begin
          if (w_cand_found) r_grant <= NUM_COL'(1) << w_cand_idx;
        end
        XFER: begin
          if (w_last_beat) begin
            r_count <= w_count_inc;
            r_ptr   <= w_next_ptr;
            r_grant <= '0;
            r_done  <= w_session_end;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m_tvalid   = w_tvalid;
  assign bus.m_tlast    = w_tlast;
  assign bus.m_tdata    = w_tdata;
  assign bus.col_tready = w_col_tready;
  assign bus.grant      = r_grant;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = r_done;
  assign bus.pkt_count  = r_count;

endmodule

// File: tb/tb_cgra_stream_arbiter.sv
// Directed self-checking bench for cgra_stream_arbiter.
module tb_cgra_stream_arbiter;
  import cgra_stream_pkg::*;

  localparam int NUM_COL = 4;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 16;

  logic clk;
  logic rst;

  cgra_stream_arbiter_if #(.NUM_COL(NUM_COL), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  cgra_stream_arbiter #(.NUM_COL(NUM_COL), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed;
  int total;
  int cyc;
  int start_cyc;
  int first_cyc;
  int done_cnt;
  int done_cyc;

  // Column source model: each column emits left[c] packets of len[c] beats.
  logic [NUM_COL-1:0] en;
  logic [NUM_COL-1:0] gate;
  int left [NUM_COL];
  int beat [NUM_COL];
  int pkt  [NUM_COL];
  int len  [NUM_COL];
  bit rand_ready;
  bit rand_valid;

  // Egress sink record and expected stream.
  logic [DATA_W-1:0]  beat_q[$];
  logic               last_q[$];
  logic [NUM_COL-1:0] gnt_q[$];
  int                 cyc_q[$];
  logic [DATA_W-1:0]  exp_q[$];
  logic               exp_last_q[$];
  logic [NUM_COL-1:0] seen_ready;

  // Beat payload encodes column, packet number and beat number.
  function automatic logic [DATA_W-1:0] word(input int c, input int p, input int b);
    return DATA_W'(c * 256 + p * 16 + b);
  endfunction

  function automatic int word_col(input logic [DATA_W-1:0] w);
    return int'((w >> 8) & 64'hF);
  endfunction

  task automatic expect_pkt(input int c, input int p, input int n);
    for (int b = 0; b < n; b++) begin
      exp_q.push_back(word(c, p, b));
      exp_last_q.push_back(b == n - 1);
    end
  endtask

  // Count of differences between the recorded and expected egress streams.
  function automatic int seq_errors();
    int e;
    e = 0;
    if (beat_q.size() != exp_q.size()) begin
      $display("  beat count %0d, want %0d", beat_q.size(), exp_q.size());
      e++;
    end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      if (beat_q[i] !== exp_q[i] || last_q[i] !== exp_last_q[i]) begin
        $display("  beat %0d: got %h/%b want %h/%b", i, beat_q[i], last_q[i], exp_q[i], exp_last_q[i]);
        e++;
      end
    end
    return e;
  endfunction

  // Count of beats whose grant is not the one-hot of the column that produced them.
  function automatic int grant_errors();
    int e;
    e = 0;
    for (int i = 0; i < beat_q.size(); i++) begin
      if (gnt_q[i] !== (NUM_COL'(1) << word_col(beat_q[i]))) e++;
    end
    return e;
  endfunction

  task automatic drive_cols();
    for (int c = 0; c < NUM_COL; c++) begin
      logic act;
      act = en[c] && (left[c] != 0) && gate[c];
      bus.col_tvalid[c] = act;
      bus.col_tlast[c]  = act && (beat[c] == len[c] - 1);
      bus.col_tdata[c*DATA_W +: DATA_W] = act ? word(c, pkt[c], beat[c]) : '0;
    end
  endtask

  task automatic init_sources();
    en = '0;
    gate = '1;
    for (int c = 0; c < NUM_COL; c++) begin
      left[c] = 0; beat[c] = 0; pkt[c] = 0; len[c] = 1;
    end
    rand_ready = 1'b0;
    rand_valid = 1'b0;
    // NOTE: bench drives DUT inputs with blocking assignments away from the clock edge.
    bus.m_tready = 1'b1;
    beat_q.delete(); last_q.delete(); gnt_q.delete(); cyc_q.delete();
    exp_q.delete(); exp_last_q.delete();
    seen_ready = '0;
    done_cnt = 0;
    done_cyc = -1;
    first_cyc = -1;
    drive_cols();
  endtask

  // One clock: record pre-edge handshakes, then update the source model after the edge.
  task automatic step();
    logic [NUM_COL-1:0] adv;
    adv = bus.col_tvalid & bus.col_tready;
    seen_ready = seen_ready | bus.col_tready;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
      if (beat_q.size() == 0) first_cyc = cyc;
      beat_q.push_back(bus.m_tdata);
      last_q.push_back(bus.m_tlast);
      gnt_q.push_back(bus.grant);
      cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < NUM_COL; c++) begin
      if (adv[c] === 1'b1) begin
        if (beat[c] == len[c] - 1) begin
          beat[c] = 0; pkt[c]++; left[c]--;
        end else begin
          beat[c]++;
        end
      end
    end
    if (rand_ready) bus.m_tready = 1'($urandom_range(0, 1));
    gate = rand_valid ? NUM_COL'($urandom) : '1;
    drive_cols();
    #1;
  endtask

  task automatic do_start(input logic m, input int limit);
    bus.start = 1'b1;
    bus.mode = m;
    bus.pkt_limit = CNT_W'(limit);
    start_cyc = cyc;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (done_cnt != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_until_count(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (int'(bus.pkt_count) == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int last_beat_cyc();
    return (cyc_q.size() == 0) ? -100 : cyc_q[cyc_q.size() - 1];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.grant !== '0) $display("FAIL reset_grant: got %b want 0", bus.grant); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
    total++; if (bus.pkt_count !== '0) $display("FAIL reset_pkt_count: got %0d want 0", bus.pkt_count); else passed++;
    total++; if ({bus.m_tvalid, bus.m_tlast, bus.col_tready} !== '0 || bus.m_tdata !== '0)
      $display("FAIL reset_streams: got v=%b l=%b r=%b d=%h want all 0", bus.m_tvalid, bus.m_tlast, bus.col_tready, bus.m_tdata);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_ordered();
    bit ok;
    int lasts;
    init_sources();
    for (int c = 0; c < NUM_COL; c++) begin
      en[c] = 1'b1; left[c] = 1; len[c] = 3;
      expect_pkt(c, 0, 3);
    end
    drive_cols();
    do_start(MODE_ORDERED, 0);
    run_to_done(100, ok);
    step(); step();
    lasts = 0;
    foreach (last_q[i]) if (last_q[i]) lasts++;
    total++; if (!ok) $display("FAIL ord_done_timeout: got no done want done within 100 cycles"); else passed++;
    total++; if (seq_errors() != 0) $display("FAIL ord_sequence: got %0d bad beats want 0", seq_errors()); else passed++;
    total++; if (lasts != 4) $display("FAIL ord_tlast_count: got %0d want 4", lasts); else passed++;
    total++; if (first_cyc != start_cyc + 2) $display("FAIL ord_first_beat: got cycle %0d want %0d", first_cyc, start_cyc + 2); else passed++;
    total++; if (done_cyc != last_beat_cyc() + 1) $display("FAIL ord_done_timing: got cycle %0d want %0d", done_cyc, last_beat_cyc() + 1); else passed++;
    total++; if (done_cnt != 1) $display("FAIL ord_done_pulses: got %0d want 1", done_cnt); else passed++;
    total++; if (bus.pkt_count !== CNT_W'(4)) $display("FAIL ord_pkt_count: got %0d want 4", bus.pkt_count); else passed++;
    total++; if (bus.busy !== 1'b0 || bus.grant !== '0) $display("FAIL ord_idle_after: got busy=%b grant=%b want 0/0", bus.busy, bus.grant); else passed++;
  endtask

  task automatic test_ordered_late();
    bit ok;
    init_sources();
    for (int c = 0; c < NUM_COL; c++) begin
      left[c] = 1; len[c] = 2;
      expect_pkt(c, 0, 2);
    end
    en[2] = 1'b1; en[3] = 1'b1;
    drive_cols();
    do_start(MODE_ORDERED, 0);
    repeat (8) step();
    total++; if (seen_ready !== '0 || beat_q.size() != 0)
      $display("FAIL late_wait: got ready=%b beats=%0d want 0/0", seen_ready, beat_q.size());
    else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL late_busy: got %b want 1", bus.busy); else passed++;
    en[0] = 1'b1; en[1] = 1'b1;
    drive_cols();
    run_to_done(100, ok);
    total++; if (!ok) $display("FAIL late_done_timeout: got no done want done within 100 cycles"); else passed++;
    total++; if (seq_errors() != 0) $display("FAIL late_sequence: got %0d bad beats want 0", seq_errors()); else passed++;
  endtask

  task automatic test_rr_limit();
    bit ok;
    int gaps;
    init_sources();
    for (int c = 0; c < NUM_COL; c++) begin
      en[c] = 1'b1; left[c] = 10; len[c] = 1;
    end
    for (int k = 0; k < 6; k++) expect_pkt(k % NUM_COL, k / NUM_COL, 1);
    drive_cols();
    do_start(MODE_RR, 6);
    repeat (3) step();
    // A second start mid-session with different settings must be ignored.
    bus.start = 1'b1; bus.mode = MODE_ORDERED; bus.pkt_limit = CNT_W'(2);
    step();
    bus.start = 1'b0;
    run_to_done(100, ok);
    step(); step();
    gaps = 0;
    for (int i = 0; i + 1 < cyc_q.size(); i++) if (cyc_q[i+1] - cyc_q[i] != 2) gaps++;
    total++; if (!ok) $display("FAIL rr_done_timeout: got no done want done within 100 cycles"); else passed++;
    total++; if (seq_errors() != 0) $display("FAIL rr_sequence: got %0d bad beats want 0", seq_errors()); else passed++;
    total++; if (grant_errors() != 0) $display("FAIL rr_grant: got %0d bad grants want 0", grant_errors()); else passed++;
    total++; if (gaps != 0) $display("FAIL rr_bubble: got %0d wrong gaps want 0", gaps); else passed++;
    total++; if (bus.pkt_count !== CNT_W'(6)) $display("FAIL rr_pkt_count: got %0d want 6", bus.pkt_count); else passed++;
    total++; if (done_cnt != 1 || done_cyc != last_beat_cyc() + 1)
      $display("FAIL rr_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, last_beat_cyc() + 1);
    else passed++;
    total++; if (bus.col_tready !== '0) $display("FAIL rr_ready_idle: got %b want 0", bus.col_tready); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    init_sources();
    for (int c = 0; c < NUM_COL; c++) begin
      en[c] = 1'b1; left[c] = 1; len[c] = c + 2;
      expect_pkt(c, 0, c + 2);
    end
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    drive_cols();
    do_start(MODE_ORDERED, 0);
    run_to_done(400, ok);
    rand_ready = 1'b0;
    rand_valid = 1'b0;
    step();
    total++; if (!ok) $display("FAIL bp_done_timeout: got no done want done within 400 cycles"); else passed++;
    total++; if (seq_errors() != 0) $display("FAIL bp_sequence: got %0d bad beats want 0", seq_errors()); else passed++;
    total++; if (grant_errors() != 0) $display("FAIL bp_grant: got %0d bad grants want 0", grant_errors()); else passed++;
    total++; if (bus.pkt_count !== CNT_W'(4)) $display("FAIL bp_pkt_count: got %0d want 4", bus.pkt_count); else passed++;
  endtask

  task automatic test_rr_skip();
    bit ok1, ok2, ok3;
    init_sources();
    en[0] = 1'b1; left[0] = 1;
    expect_pkt(0, 0, 1);
    expect_pkt(3, 0, 1);
    expect_pkt(0, 1, 1);
    drive_cols();
    do_start(MODE_RR, 3);
    run_until_count(1, 50, ok1);
    // ptr is now 1; only column 3 requests.
    en[3] = 1'b1; left[3] = 1;
    drive_cols();
    run_until_count(2, 50, ok2);
    // ptr wrapped to 0; columns 0 and 1 both request.
    left[0] = 1; en[1] = 1'b1; left[1] = 1;
    drive_cols();
    run_to_done(50, ok3);
    total++; if (!(ok1 && ok2 && ok3)) $display("FAIL skip_timeout: got %b%b%b want 111", ok1, ok2, ok3); else passed++;
    total++; if (seq_errors() != 0) $display("FAIL skip_sequence: got %0d bad beats want 0", seq_errors()); else passed++;
    total++; if (gnt_q.size() != 3 || gnt_q[1] !== 4'b1000 || gnt_q[2] !== 4'b0001)
      $display("FAIL skip_grants: got %0d beats want grants 1000 then 0001", gnt_q.size());
    else passed++;
    total++; if (bus.pkt_count !== CNT_W'(3)) $display("FAIL skip_pkt_count: got %0d want 3", bus.pkt_count); else passed++;
  endtask

  task automatic test_rst_mid();
    bit ok;
    init_sources();
    for (int c = 0; c < NUM_COL; c++) begin
      en[c] = 1'b1; left[c] = 1; len[c] = (c == 0) ? 6 : 1;
    end
    drive_cols();
    do_start(MODE_ORDERED, 0);
    step(); step();
    total++; if (bus.m_tvalid !== 1'b1 || bus.grant !== 4'b0001)
      $display("FAIL rst_pre_xfer: got v=%b grant=%b want 1/0001", bus.m_tvalid, bus.grant);
    else passed++;
    // Reset and start together: reset must win.
    rst = 1'b1;
    bus.start = 1'b1; bus.mode = MODE_RR;
    step();
    total++; if (bus.busy !== 1'b0 || bus.grant !== '0 || bus.done !== 1'b0 || bus.pkt_count !== '0)
      $display("FAIL rst_state: got busy=%b grant=%b done=%b cnt=%0d want 0", bus.busy, bus.grant, bus.done, bus.pkt_count);
    else passed++;
    total++; if ({bus.m_tvalid, bus.m_tlast, bus.col_tready} !== '0 || bus.m_tdata !== '0)
      $display("FAIL rst_streams: got v=%b l=%b r=%b d=%h want all 0", bus.m_tvalid, bus.m_tlast, bus.col_tready, bus.m_tdata);
    else passed++;
    rst = 1'b0;
    bus.start = 1'b0;
    step();
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_start_dropped: got busy=%b want 0", bus.busy); else passed++;
    init_sources();
    for (int c = 0; c < NUM_COL; c++) begin
      en[c] = 1'b1; left[c] = 1; len[c] = 1;
      expect_pkt(c, 0, 1);
    end
    drive_cols();
    do_start(MODE_ORDERED, 0);
    run_to_done(100, ok);
    total++; if (!ok) $display("FAIL rst_clean_timeout: got no done want done within 100 cycles"); else passed++;
    total++; if (seq_errors() != 0) $display("FAIL rst_clean_sequence: got %0d bad beats want 0", seq_errors()); else passed++;
    total++; if (bus.pkt_count !== CNT_W'(4)) $display("FAIL rst_clean_pkt_count: got %0d want 4", bus.pkt_count); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    passed = 0;
    total = 0;
    cyc = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode = MODE_ORDERED;
    bus.pkt_limit = '0;
    init_sources();
    test_reset();
    test_ordered();
    test_ordered_late();
    test_rr_limit();
    test_backpressure();
    test_rr_skip();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
